// File: rtl/stream_fifo.sv
// Single-clock first-word-fall-through stream FIFO with occupancy count and status flags.
// Optional peak-occupancy tracker enabled by defining STREAM_FIFO_PEAK_EN.
module stream_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
`ifdef STREAM_FIFO_PEAK_EN
  ,
  output logic [ADDR_WIDTH:0]   peak_count
`endif
);

  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   LP_DEPTH  = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LP_AFULL  = CW'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0]   LP_AEMPTY = CW'(AEMPTY_LVL);
  localparam logic [ADDR_WIDTH:0]   LP_CNT1   = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] LP_PTR1   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_in_ready;
  logic                  w_out_valid;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH:0]   w_count_next;

  // Readiness comes only from the registered count, so a full FIFO refuses a
  // write even while it is being popped in the same cycle.
  assign w_in_ready  = (r_count < LP_DEPTH);
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid && w_in_ready;
  assign w_pop       = out_ready && w_out_valid;

  always_comb begin
    w_count_next = r_count;
    if (clear) begin
      w_count_next = '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + LP_CNT1;
        2'b01:   w_count_next = r_count - LP_CNT1;
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LP_PTR1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PTR1;
      r_count <= w_count_next;
      if (in_valid && !w_in_ready)  r_overflow  <= 1'b1;
      if (out_ready && !w_out_valid) r_underflow <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset and clear.
  always_ff @(posedge clk) begin
    if (w_push && !clear) r_mem[r_wr_ptr] <= in_data;
  end

`ifdef STREAM_FIFO_PEAK_EN
  logic [ADDR_WIDTH:0] r_peak;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_peak <= '0;
    end else if (clear) begin
      r_peak <= '0;
    end else if (w_count_next > r_peak) begin
      r_peak <= w_count_next;
    end
  end

  assign peak_count = r_peak;
`endif

  assign in_ready     = w_in_ready;
  assign out_valid    = w_out_valid;
  assign out_data     = r_mem[r_rd_ptr];
  assign fifo_count   = r_count;
  assign almost_full  = (r_count >= LP_AFULL);
  assign almost_empty = (r_count <= LP_AEMPTY);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_stream_fifo.sv
// Directed self-checking bench for stream_fifo (DATA_WIDTH=16, ADDR_WIDTH=3).
// Peak-count checks run only when STREAM_FIFO_PEAK_EN is defined.
module tb_stream_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [3:0]  fifo_count;
  logic        almost_full;
  logic        almost_empty;
  logic        overflow;
  logic        underflow;
`ifdef STREAM_FIFO_PEAK_EN
  logic [3:0]  peak_count;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  stream_fifo #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(3)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .fifo_count  (fifo_count),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
`ifdef STREAM_FIFO_PEAK_EN
    ,
    .peak_count  (peak_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_afull",     32'(almost_full), 32'd0);
    check("rst_aempty",    32'(almost_empty), 32'd1);
    check("rst_count",     32'(fifo_count), 32'd0);
    check("rst_ovf",       32'(overflow), 32'd0);
    check("rst_unf",       32'(underflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Fill to full, then one refused write
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      tick();
      check("fill_count", 32'(fifo_count), 32'(i));
      check("fill_afull", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
      check("fill_ready", 32'(in_ready), (i < 8) ? 32'd1 : 32'd0);
      check("fill_head",  32'(out_data), 32'h1);
    end
    in_data = 16'h0009;
    tick();
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_count", 32'(fifo_count), 32'd8);
    in_valid = 1'b0;

    // Drain in order
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_data",  32'(out_data), 32'(i));
      check("drain_valid", 32'(out_valid), 32'd1);
      tick();
      check("drain_count",  32'(fifo_count), 32'(8 - i));
      check("drain_aempty", 32'(almost_empty), ((8 - i) <= 2) ? 32'd1 : 32'd0);
    end
    check("empty_valid", 32'(out_valid), 32'd0);
    check("unf_before",  32'(underflow), 32'd0);
    tick();
    check("unf_set", 32'(underflow), 32'd1);
    out_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_unf", 32'(underflow), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);

    // Steady state at count 4 across pointer wrap
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 16'h10 + 16'(i);
      tick();
    end
    check("ss_count0", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = 16'h14 + 16'(k);
      check("ss_head", 32'(out_data), 32'h10 + 32'(k));
      tick();
      check("ss_count", 32'(fifo_count), 32'd4);
    end
    check("ss_head_end", 32'(out_data), 32'h24);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Full with simultaneous push and pop: only the pop happens
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'h40 + 16'(i);
      tick();
    end
    check("full_count", 32'(fifo_count), 32'd8);
    in_data   = 16'h48;
    out_ready = 1'b1;
    tick();
    check("fpp_count", 32'(fifo_count), 32'd7);
    check("fpp_ready", 32'(in_ready), 32'd1);
    check("fpp_head",  32'(out_data), 32'h41);
    check("fpp_ovf",   32'(overflow), 32'd1);
    out_ready = 1'b0;
    tick();
    check("retry_count", 32'(fifo_count), 32'd8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b0;
    check("c5_count", 32'(fifo_count), 32'd5);
    check("c5_head",  32'(out_data), 32'h44);
    check("c5_ovf",   32'(overflow), 32'd1);

    // Clear dominates a concurrent write
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_count", 32'(fifo_count), 32'd0);
    check("clr_ovf2",  32'(overflow), 32'd0);
    check("clr_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'hA1 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_count",  32'(fifo_count), 32'd0);
    check("arst_ready",  32'(in_ready), 32'd1);
    check("arst_valid",  32'(out_valid), 32'd0);
    check("arst_afull",  32'(almost_full), 32'd0);
    check("arst_aempty", 32'(almost_empty), 32'd1);
    @(negedge clk);
    reset_n  = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hB1;
    tick();
    in_valid = 1'b0;
    check("post_rst_count", 32'(fifo_count), 32'd1);
    check("post_rst_head",  32'(out_data), 32'hB1);

`ifdef STREAM_FIFO_PEAK_EN
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 16'h60 + 16'(i);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    out_ready = 1'b0;
    check("peak_count", 32'(peak_count), 32'd6);
    check("peak_empty", 32'(fifo_count), 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("peak_clr", 32'(peak_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, log2 of depth; DEPTH = 2^ADDR_WIDTH.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-2, almost_full threshold in entries.
REQ-004 SHALL have parameter AEMPTY_LVL, default 2, almost_empty threshold in entries.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port clear  input  1  synchronous flush.
REQ-008 SHALL have port in_valid  input  1  write request.
REQ-009 SHALL have port in_data  input  DATA_WIDTH  write sample.
REQ-010 SHALL have port in_ready  output  1  FIFO accepts a write this cycle.
REQ-011 SHALL have port out_valid  output  1  out_data holds the head entry.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  head entry, first-word-fall-through.
REQ-013 SHALL have port out_ready  input  1  consumer takes the head.
REQ-014 SHALL have port fifo_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have ports almost_full, almost_empty, overflow, underflow  output  1 each  status flags.

Function
REQ-016 in_ready SHALL equal (fifo_count < DEPTH), decoded from registered state only; no combinational path from out_ready.
REQ-017 out_valid SHALL equal (fifo_count != 0); out_data SHALL be mem[rd_ptr], read combinationally.
REQ-018 A push SHALL occur when in_valid && in_ready: mem[wr_ptr] <= in_data, wr_ptr increments.
REQ-019 A pop SHALL occur when out_valid && out_ready: rd_ptr increments.
REQ-020 fifo_count SHALL be +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-021 Pointers SHALL be ADDR_WIDTH bits and wrap from DEPTH-1 to 0 with no gap.
REQ-022 When full, a write SHALL be refused even if a pop occurs in the same cycle; the write is accepted the next cycle.
REQ-023 Data pushed into an empty FIFO SHALL appear on out_data with out_valid=1 in the following cycle (1-cycle latency).
REQ-024 almost_full SHALL be registered-state decode of fifo_count >= AFULL_LVL; almost_empty of fifo_count <= AEMPTY_LVL.
REQ-025 overflow SHALL set sticky on in_valid && !in_ready; underflow sticky on out_ready && !out_valid; both clear only on clear or reset.
REQ-026 clear SHALL zero pointers, fifo_count and sticky flags at the next edge, dominating push and pop in that cycle.
REQ-027 Memory contents SHALL NOT be reset or cleared.

Reset
REQ-028 On reset_n low, immediately and independent of clk: rd_ptr=0, wr_ptr=0, fifo_count=0, overflow=0, underflow=0.
REQ-029 Resulting outputs during reset: in_ready=1, out_valid=0, almost_full=0, almost_empty=1.
REQ-030 Reset assertion mid-stream SHALL discard all entries; the first push after reset_n deassertion lands at address 0.

Configuration
REQ-031 Macro STREAM_FIFO_PEAK_EN defined: add output peak_count (ADDR_WIDTH+1), holding the maximum fifo_count since reset/clear, updated each cycle with the post-update count; resets/clears to 0.
REQ-032 Macro undefined: no peak_count port and no peak logic; all other behaviour identical.

Verification (DATA_WIDTH=16, ADDR_WIDTH=3)
REQ-033 Push 0x0001..0x0008 with out_ready=0 -> fifo_count=8, in_ready=0, almost_full=1 from count 6; 9th in_valid sets overflow=1, count stays 8.
REQ-034 Then out_ready=1, in_valid=0 for 8 cycles -> out_data 0x0001..0x0008 in order, count reaches 0, out_valid=0; extra out_ready sets underflow=1.
REQ-035 Count=4, in_valid=1 and out_ready=1 for 20 cycles -> count stays 4, pointers wrap past 7, data order preserved.
REQ-036 Count=8, in_valid=1 and out_ready=1 same cycle -> pop only, count=7, in_ready=1 next cycle.
REQ-037 Count=5 with overflow=1; assert clear together with in_valid -> next cycle count=0, overflow=0, out_valid=0; separately, reset_n low mid-stream -> outputs per REQ-029 without a clk edge.
REQ-038 With STREAM_FIFO_PEAK_EN, fill to 6 then drain to 0 -> peak_count=6; after clear peak_count=0.
